ntt_addr_gen: RTL and testbench
===============================

Name: ntt_addr_gen

Overview:
- Upstream sequencer for the NTT datapath: walks all log2(N) Cooley-Tukey stages in order.
- Issues one butterfly descriptor per handshake: addr_a, addr_b and twiddle index.
- Descriptors feed the coefficient-RAM read port and twiddle ROM whose outputs drive ntt_butterfly.
- Inserts a programmable drain gap between stages so results written back by the butterfly pipeline land before the next stage reads them.

Parameters:
- N, 256, transform length; power of two, >= 4.
- LOG2N, $clog2(N), number of stages.
- ADDR_W, $clog2(N), coefficient address width.
- PIPE_LAT, 3, cycles between a stage's last issue and the next stage's first issue (read + butterfly + write-back latency); 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  high in RUN, WAIT, DONE.
- done  out  1  one-cycle pulse at transform end.
- out_valid  out  1  descriptor valid.
- out_ready  in  1  downstream accepts descriptor.
- addr_a  out  ADDR_W  upper butterfly operand address.
- addr_b  out  ADDR_W  lower operand address, addr_a + len.
- tw_idx  out  ADDR_W  twiddle ROM index, 1..N-1.
- stage  out  $clog2(LOG2N)  current stage number.
- last_in_stage  out  1  high with the final descriptor of a stage.

Behaviour:
- Reset (async, any state): state=IDLE; all counters 0; busy, done, out_valid, last_in_stage = 0; addr_a, addr_b, tw_idx, stage = 0.
- Counters:
  - s: stage, 0..LOG2N-1.
  - g: group within stage, 0..2^s-1.
  - j: offset within group, 0..len-1, where len = N>>(s+1).
- Descriptor, all registered outputs:
  - addr_a = (g << (LOG2N-s)) + j
  - addr_b = addr_a + len
  - tw_idx = (1<<s) + g
  - No overflow possible within ADDR_W.
- Iteration order: j fastest, then g, then s. Each stage issues exactly N/2 descriptors; N/2·LOG2N in total.
- FSM states: IDLE, RUN, WAIT, DONE.
  - IDLE: start=1 -> RUN next cycle, counters 0, out_valid=1 with the first descriptor (0, len0, 1).
  - RUN: out_valid=1. Descriptor fields are held stable while out_ready=0; out_valid is never dropped without a handshake. On out_valid&&out_ready, advance counters.
  - On the handshake of the last descriptor of a stage (last_in_stage=1), the next state depends on PIPE_LAT and whether this is the final stage:
    - PIPE_LAT>0: -> WAIT, loading a wait counter with PIPE_LAT.
    - PIPE_LAT=0 and not final stage: stay in RUN with the next stage's first descriptor in the following cycle.
    - PIPE_LAT=0 and final stage: -> DONE.
  - WAIT: out_valid=0; count down PIPE_LAT cycles, then -> RUN (next stage) if s < LOG2N-1, else -> DONE.
  - DONE: done=1 for exactly one cycle, busy=1, then -> IDLE.
- start while busy is ignored; it is not queued.
- out_ready while out_valid=0 has no effect.
- Reset mid-transform aborts immediately; no done pulse.
- Timing (start sampled in cycle 0, out_ready tied high): the final handshake occurs in cycle t; done pulses in cycle t+PIPE_LAT+1.

Decomposition:
- Shared package ntt_pkg:
  - ntt_agu_state_e enum {IDLE, RUN, WAIT, DONE}.
  - Function ntt_log2 for parameter derivation.
  - Typedef ntt_bf_desc_t {addr_a, addr_b, tw_idx, stage, last_in_stage} for passing descriptors into the datapath.
- No sub-module: counters and FSM live in one module.
- The twiddle ROM and RAM are separate blocks downstream.

Test Plan:
- N=8, PIPE_LAT=3, out_ready=1, start in cycle 0 -> descriptors (a,b,tw):
  - cycles 1-4: (0,4,1) (1,5,1) (2,6,1) (3,7,1)
  - cycles 5-7: out_valid=0
  - cycles 8-11: (0,2,2) (1,3,2) (4,6,3) (5,7,3)
  - cycles 15-18: (0,1,4) (2,3,5) (4,5,6) (6,7,7)
  - cycle 22: done=1, then busy=0.
  - last_in_stage high in cycles 4, 11, 18.
- Same as above with out_ready toggling 1,0,0,1 repeating -> identical descriptor sequence; fields stable while stalled; done still exactly one pulse.
- N=256, PIPE_LAT=0, out_ready=1 -> 1024 consecutive valid cycles; tw_idx covers 1..255 with no gaps; done one cycle after the final handshake.
- start pulsed again in cycle 6 of the first scenario -> ignored; sequence unchanged; a single done pulse.
- rst asserted asynchronously mid-cycle during stage 1 -> out_valid, busy, done = 0 immediately. After release, start -> sequence restarts at (0,4,1).
- Reset values: all outputs 0 with start=0 held for 10 cycles; out_valid never rises.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT address generator and its datapath.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } ntt_agu_state_e;

  localparam int NTT_DESC_ADDR_W  = 16;
  localparam int NTT_DESC_STAGE_W = 4;

  typedef struct packed {
    logic [NTT_DESC_ADDR_W-1:0]  addr_a;
    logic [NTT_DESC_ADDR_W-1:0]  addr_b;
    logic [NTT_DESC_ADDR_W-1:0]  tw_idx;
    logic [NTT_DESC_STAGE_W-1:0] stage;
    logic                        last_in_stage;
  } ntt_bf_desc_t;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int ntt_log2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Cooley-Tukey butterfly descriptor sequencer: walks every stage/group/offset
// and inserts a PIPE_LAT-cycle drain gap between stages.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int N        = 256,
  parameter int LOG2N    = ntt_log2(N),
  parameter int ADDR_W   = ntt_log2(N),
  parameter int PIPE_LAT = 3,
  localparam int STAGE_W = ntt_log2(LOG2N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic [ADDR_W-1:0]  tw_idx,
  output logic [STAGE_W-1:0] stage,
  output logic               last_in_stage
);

  localparam int WAIT_W = (PIPE_LAT > 0) ? ntt_log2(PIPE_LAT + 1) : 1;

  ntt_agu_state_e state_q, state_n;
  logic [STAGE_W-1:0] s_q, s_n;
  logic [ADDR_W-1:0]  g_q, g_n, j_q, j_n;
  logic [WAIT_W-1:0]  wait_q, wait_n;

  logic [ADDR_W-1:0]  len_m1, grp_m1;
  logic               stage_end, final_stage;

  int addr_a_i, len_n_i, tw_i;
  logic last_n;

  assign len_m1      = ADDR_W'((N >> (int'(s_q) + 1)) - 1);
  assign grp_m1      = ADDR_W'((1 << int'(s_q)) - 1);
  assign stage_end   = (j_q == len_m1) && (g_q == grp_m1);
  assign final_stage = (s_q == STAGE_W'(LOG2N - 1));

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == RUN);

  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    g_n     = g_q;
    j_n     = j_q;
    wait_n  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          s_n     = '0;
          g_n     = '0;
          j_n     = '0;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (!stage_end) begin
            if (j_q == len_m1) begin
              j_n = '0;
              g_n = g_q + ADDR_W'(1);
            end else begin
              j_n = j_q + ADDR_W'(1);
            end
          end else if (PIPE_LAT > 0) begin
            // Counters hold the finished stage until the drain gap ends.
            state_n = WAIT;
            wait_n  = WAIT_W'(PIPE_LAT);
          end else if (final_stage) begin
            state_n = DONE;
          end else begin
            s_n = s_q + STAGE_W'(1);
            g_n = '0;
            j_n = '0;
          end
        end
      end
      WAIT: begin
        if (wait_q <= WAIT_W'(1)) begin
          if (final_stage) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            s_n     = s_q + STAGE_W'(1);
            g_n     = '0;
            j_n     = '0;
          end
        end else begin
          wait_n = wait_q - WAIT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Descriptor for the counters that will be current next cycle.
  always_comb begin
    len_n_i  = N >> (int'(s_n) + 1);
    addr_a_i = (int'(g_n) << (LOG2N - int'(s_n))) + int'(j_n);
    tw_i     = (1 << int'(s_n)) + int'(g_n);
    last_n   = (int'(j_n) == len_n_i - 1) && (int'(g_n) == (1 << int'(s_n)) - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      s_q           <= '0;
      g_q           <= '0;
      j_q           <= '0;
      wait_q        <= '0;
      addr_a        <= '0;
      addr_b        <= '0;
      tw_idx        <= '0;
      stage         <= '0;
      last_in_stage <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      g_q     <= g_n;
      j_q     <= j_n;
      wait_q  <= wait_n;
      if (state_n == RUN) begin
        addr_a        <= ADDR_W'(addr_a_i);
        addr_b        <= ADDR_W'(addr_a_i + len_n_i);
        tw_idx        <= ADDR_W'(tw_i);
        stage         <= s_n;
        last_in_stage <= last_n;
      end else begin
        addr_a        <= '0;
        addr_b        <= '0;
        tw_idx        <= '0;
        stage         <= '0;
        last_in_stage <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench: a small N=8/PIPE_LAT=3 instance and a full N=256/PIPE_LAT=0 instance.
module tb_ntt_addr_gen;

  localparam int NA = 8;
  localparam int PA = 3;
  localparam int NB = 256;
  localparam int PB = 0;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
    int last;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_ready = 1'b1;
  logic       a_busy, a_done, a_valid, a_last;
  logic [2:0] a_addr_a, a_addr_b, a_tw;
  logic [1:0] a_stage;

  logic       b_start = 1'b0, b_ready = 1'b1;
  logic       b_busy, b_done, b_valid, b_last;
  logic [7:0] b_addr_a, b_addr_b, b_tw;
  logic [2:0] b_stage;

  ntt_addr_gen #(.N(NA), .PIPE_LAT(PA)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .out_valid(a_valid), .out_ready(a_ready), .addr_a(a_addr_a), .addr_b(a_addr_b),
    .tw_idx(a_tw), .stage(a_stage), .last_in_stage(a_last)
  );

  ntt_addr_gen #(.N(NB), .PIPE_LAT(PB)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .out_valid(b_valid), .out_ready(b_ready), .addr_a(b_addr_a), .addr_b(b_addr_b),
    .tw_idx(b_tw), .stage(b_stage), .last_in_stage(b_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];

  // Reference: stage s splits the array into 2^s blocks of size 2*len; each
  // block pairs element j with j+len and uses twiddle 2^s + block.
  task automatic fill(input int n, input int p, input bit timed, input bit to_b);
    int lg, len, idx;
    exp_t e;
    lg = $clog2(n);
    for (int s = 0; s < lg; s++) begin
      len = n / (2 ** (s + 1));
      idx = 0;
      for (int g = 0; g < 2 ** s; g++) begin
        for (int j = 0; j < len; j++) begin
          e.a    = g * 2 * len + j;
          e.b    = e.a + len;
          e.tw   = 2 ** s + g;
          e.st   = s;
          e.last = (idx == n / 2 - 1) ? 1 : 0;
          e.cyc  = timed ? 1 + s * (n / 2 + p) + idx : -1;
          if (to_b) qb.push_back(e);
          else      qa.push_back(e);
          idx++;
        end
      end
    end
  endtask

  int na = 0, nb = 0;
  int t0a = 0, t0b = 0;
  int last_hs_a = 0, last_hs_b = 0;
  int dones_a = 0, dones_b = 0;
  int hs_b = 0;
  bit [255:0] tw_seen;

  bit toggle = 1'b0;
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) begin
        a_ready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end else begin
        a_ready = 1'b1;
        k = 0;
      end
    end
  end

  // Monitor A
  bit prev_stall = 1'b0;
  int pa_a, pa_b, pa_tw, pa_st;
  always @(negedge clk) begin
    exp_t e;
    na++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("a_stall_valid", int'(a_valid), 1);
        chk("a_stall_addr_a", int'(a_addr_a), pa_a);
        chk("a_stall_addr_b", int'(a_addr_b), pa_b);
        chk("a_stall_tw", int'(a_tw), pa_tw);
        chk("a_stall_stage", int'(a_stage), pa_st);
      end
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_descriptor", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_addr_a", int'(a_addr_a), e.a);
          chk("a_addr_b", int'(a_addr_b), e.b);
          chk("a_tw_idx", int'(a_tw), e.tw);
          chk("a_stage", int'(a_stage), e.st);
          chk("a_last", int'(a_last), e.last);
          if (e.cyc >= 0) chk("a_issue_cycle", na - t0a, e.cyc);
        end
        last_hs_a = na - t0a;
      end
      if (a_done) begin
        dones_a++;
        chk("a_done_cycle", na - t0a, last_hs_a + PA + 1);
        chk("a_done_queue_empty", qa.size(), 0);
        chk("a_done_busy", int'(a_busy), 1);
      end
      prev_stall = a_valid && !a_ready;
      pa_a = int'(a_addr_a); pa_b = int'(a_addr_b);
      pa_tw = int'(a_tw); pa_st = int'(a_stage);
    end
  end

  // Monitor B
  always @(negedge clk) begin
    exp_t e;
    nb++;
    if (!rst) begin
      if (b_valid && b_ready) begin
        hs_b++;
        tw_seen[b_tw] = 1'b1;
        if (qb.size() == 0) begin
          chk("b_unexpected_descriptor", 1, 0);
        end else begin
          e = qb.pop_front();
          if ((int'(b_addr_a) != e.a) || (int'(b_addr_b) != e.b) || (int'(b_tw) != e.tw) ||
              (int'(b_stage) != e.st) || (int'(b_last) != e.last) || (nb - t0b != e.cyc)) begin
            chk("b_descriptor_a", int'(b_addr_a), e.a);
            chk("b_descriptor_b", int'(b_addr_b), e.b);
            chk("b_descriptor_tw", int'(b_tw), e.tw);
            chk("b_descriptor_cycle", nb - t0b, e.cyc);
          end else begin
            checks++;
          end
        end
        last_hs_b = nb - t0b;
      end
      if (b_done) begin
        dones_b++;
        chk("b_done_cycle", nb - t0b, last_hs_b + PB + 1);
      end
    end
  end

  task automatic start_a();
    @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk);
    t0a = na;
    #1 a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int d0;
    bit seen;
    d0 = dones_a;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dones_a > d0) seen = 1'b1;
    end
    chk("a_done_within_budget", int'(seen), 1);
    @(posedge clk);
    #2;
    chk("a_busy_after_done", int'(a_busy), 0);
    chk("a_done_single_pulse", dones_a, d0 + 1);
  endtask

  initial begin
    bit ok;
    int d0;

    // Reset values, start held low
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_outputs_a", int'({a_busy, a_done, a_valid, a_last, a_addr_a, a_addr_b, a_tw, a_stage}), 0);
      chk("rst_valid_b", int'({b_busy, b_done, b_valid}), 0);
    end

    // Scenario 1: N=8, ready high
    fill(NA, PA, 1'b1, 1'b0);
    start_a();
    wait_done_a(100);

    // Scenario 2: ready toggling 1,0,0,1
    fill(NA, PA, 1'b0, 1'b0);
    toggle = 1'b1;
    start_a();
    wait_done_a(200);
    toggle = 1'b0;
    repeat (2) @(posedge clk);

    // Scenario 3: start re-pulsed while busy is ignored
    fill(NA, PA, 1'b1, 1'b0);
    d0 = dones_a;
    start_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_done_a(100);
    repeat (30) @(posedge clk);
    chk("a_start_ignored_single_done", dones_a, d0 + 1);
    chk("a_idle_after_ignored_start", int'(a_busy), 0);

    // Scenario 4: async reset during stage 1
    fill(NA, PA, 1'b0, 1'b0);
    d0 = dones_a;
    start_a();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_valid && a_stage == 2'd1) ok = 1'b1;
    end
    chk("a_reached_stage1", int'(ok), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("a_midreset_valid", int'(a_valid), 0);
    chk("a_midreset_busy", int'(a_busy), 0);
    chk("a_midreset_done", int'(a_done), 0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("a_no_done_on_abort", dones_a, d0);
    fill(NA, PA, 1'b1, 1'b0);
    start_a();
    wait_done_a(100);

    // Scenario 5: N=256, PIPE_LAT=0, ready high
    fill(NB, PB, 1'b1, 1'b1);
    tw_seen = '0;
    hs_b = 0;
    d0 = dones_b;
    @(posedge clk);
    #1 b_start = 1'b1;
    @(posedge clk);
    t0b = nb;
    #1 b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (dones_b > d0) ok = 1'b1;
    end
    chk("b_done_within_budget", int'(ok), 1);
    chk("b_handshakes", hs_b, NB / 2 * $clog2(NB));
    chk("b_done_at", last_hs_b, NB / 2 * $clog2(NB));
    chk("b_queue_empty", qb.size(), 0);
    ok = 1'b1;
    for (int i = 1; i < NB; i++) if (!tw_seen[i]) ok = 1'b0;
    chk("b_tw_coverage", int'(ok), 1);
    chk("b_tw_zero_unused", int'(tw_seen[0]), 0);
    @(posedge clk);
    #2;
    chk("b_busy_after_done", int'(b_busy), 0);
    chk("b_single_done", dones_b, d0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
